// File: rtl/typing_round_ctrl_pkg.sv
// Shared types and constants for the speed-typing round sequencer.
// Imported by typing_round_ctrl.
package typing_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_CLEAR,
    ST_OVER,
    ST_WIN
  } state_t;

  localparam logic [1:0] DIFF_EASY = 2'd1;
  localparam logic [1:0] DIFF_MED  = 2'd2;
  localparam logic [1:0] DIFF_HARD = 2'd3;

  localparam int LEVEL_W = 6;
  localparam int CHAR_W  = 8;
  localparam int SCORE_W = 16;
  localparam int ERR_W   = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

endpackage

// File: rtl/typing_round_ctrl.sv
// Game-round sequencer: loads the level timer, counts keystrokes,
// advances levels and ends the game on timeout or final level.
module typing_round_ctrl
  import typing_round_ctrl_pkg::*;
#(
  parameter int MAX_LEVEL  = 10,
  parameter int BASE_CHARS = 4,
  parameter int CHAR_STEP  = 1,
  parameter int MAX_CHARS  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  difficulty_sel,
  input  logic        key_valid,
  input  logic        key_match,
  input  logic        timeout,
  output logic        load_timer,
  output logic        timer_enable,
  output logic [7:0]  num_char,
  output logic [1:0]  difficulty,
  output logic [5:0]  level,
  output logic [7:0]  char_index,
  output logic [15:0] score,
  output logic [7:0]  errors,
  output logic        round_active,
  output logic        game_over,
  output logic        game_won
);

  localparam logic [LEVEL_W-1:0] LVL_LAST = LEVEL_W'(MAX_LEVEL);
  localparam logic [CHAR_W-1:0]  CH_BASE  = CHAR_W'(BASE_CHARS);
  localparam logic [CHAR_W:0]    CH_STEP  = (CHAR_W+1)'(CHAR_STEP);
  localparam logic [CHAR_W:0]    CH_MAX   = (CHAR_W+1)'(MAX_CHARS);

  state_t state;
  state_t state_nxt;

  logic key_hit;
  logic key_miss;
  logic done;
  logic last_lvl;

  logic [CHAR_W:0]   num_sum;
  logic [CHAR_W-1:0] num_step;

  logic               load_d;
  logic               en_d;
  logic [CHAR_W-1:0]  num_d;
  logic [1:0]         diff_d;
  logic [LEVEL_W-1:0] level_d;
  logic [CHAR_W-1:0]  ci_d;
  logic [SCORE_W-1:0] score_d;
  logic [ERR_W-1:0]   err_d;
  logic               active_d;
  logic               over_d;
  logic               won_d;

  assign key_hit  = key_valid & key_match;
  assign key_miss = key_valid & ~key_match;
  assign done     = key_hit && (char_index == num_char - 8'd1);
  assign last_lvl = (level == LVL_LAST);

  // 9-bit sum so a large step cannot wrap past the ceiling
  assign num_sum  = {1'b0, num_char} + CH_STEP;
  assign num_step = (num_sum > CH_MAX) ? CH_MAX[CHAR_W-1:0]
                                       : num_sum[CHAR_W-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (done)         state_nxt = ST_CLEAR;
        else if (timeout) state_nxt = ST_OVER;
      end
      ST_CLEAR: begin
        if (last_lvl) state_nxt = ST_WIN;
        else          state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_d   = (state_nxt == ST_LOAD);
    en_d     = (state_nxt == ST_PLAY);
    active_d = (state_nxt == ST_PLAY);
    over_d   = (state_nxt == ST_OVER);
    won_d    = (state_nxt == ST_WIN);
    num_d    = num_char;
    diff_d   = difficulty;
    level_d  = level;
    ci_d     = char_index;
    score_d  = score;
    err_d    = errors;
    unique case (state)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start) begin
          diff_d  = (difficulty_sel == 2'd0) ? DIFF_EASY
                                             : difficulty_sel;
          level_d = 6'd1;
          num_d   = CH_BASE;
          ci_d    = '0;
          score_d = '0;
          err_d   = '0;
        end
      end
      ST_PLAY: begin
        if (key_hit) begin
          ci_d = char_index + 8'd1;
          if (score != SCORE_MAX) score_d = score + 16'd1;
        end
        if (key_miss && errors != ERR_MAX)
          err_d = errors + 8'd1;
      end
      ST_CLEAR: begin
        if (!last_lvl) begin
          level_d = level + 6'd1;
          num_d   = num_step;
        end
      end
      default: ;
    endcase
    if (state_nxt == ST_LOAD) ci_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      load_timer   <= 1'b0;
      timer_enable <= 1'b0;
      num_char     <= CH_BASE;
      difficulty   <= DIFF_EASY;
      level        <= 6'd1;
      char_index   <= '0;
      score        <= '0;
      errors       <= '0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      load_timer   <= load_d;
      timer_enable <= en_d;
      num_char     <= num_d;
      difficulty   <= diff_d;
      level        <= level_d;
      char_index   <= ci_d;
      score        <= score_d;
      errors       <= err_d;
      round_active <= active_d;
      game_over    <= over_d;
      game_won     <= won_d;
    end
  end

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Bench for typing_round_ctrl: default build plus a short 3-level build.
// Expected timer loads are queued at stimulus time and checked on pulse.
module tb_typing_round_ctrl;

  logic clk;
  logic resetn;

  logic        a_start, a_key_valid, a_key_match, a_timeout;
  logic [1:0]  a_sel;
  logic        a_load_timer, a_timer_enable;
  logic [7:0]  a_num_char, a_char_index, a_errors;
  logic [1:0]  a_difficulty;
  logic [5:0]  a_level;
  logic [15:0] a_score;
  logic        a_round_active, a_game_over, a_game_won;

  logic        b_start, b_key_valid, b_key_match, b_timeout;
  logic [1:0]  b_sel;
  logic        b_load_timer, b_timer_enable;
  logic [7:0]  b_num_char, b_char_index, b_errors;
  logic [1:0]  b_difficulty;
  logic [5:0]  b_level;
  logic [15:0] b_score;
  logic        b_round_active, b_game_over, b_game_won;

  int total = 0;
  int bad   = 0;

  logic [13:0] qa[$];
  logic [13:0] qb[$];

  typing_round_ctrl u_a (
    .clk(clk), .resetn(resetn),
    .start(a_start), .difficulty_sel(a_sel),
    .key_valid(a_key_valid), .key_match(a_key_match),
    .timeout(a_timeout),
    .load_timer(a_load_timer), .timer_enable(a_timer_enable),
    .num_char(a_num_char), .difficulty(a_difficulty),
    .level(a_level), .char_index(a_char_index),
    .score(a_score), .errors(a_errors),
    .round_active(a_round_active), .game_over(a_game_over),
    .game_won(a_game_won)
  );

  typing_round_ctrl #(
    .MAX_LEVEL(3), .BASE_CHARS(4), .CHAR_STEP(2), .MAX_CHARS(5)
  ) u_b (
    .clk(clk), .resetn(resetn),
    .start(b_start), .difficulty_sel(b_sel),
    .key_valid(b_key_valid), .key_match(b_key_match),
    .timeout(b_timeout),
    .load_timer(b_load_timer), .timer_enable(b_timer_enable),
    .num_char(b_num_char), .difficulty(b_difficulty),
    .level(b_level), .char_index(b_char_index),
    .score(b_score), .errors(b_errors),
    .round_active(b_round_active), .game_over(b_game_over),
    .game_won(b_game_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [13:0] e;
    if (a_load_timer === 1'b1) begin
      if (qa.size() == 0) chk("a_lt_unexp", a_load_timer, 0);
      else begin
        e = qa.pop_front();
        chk("a_lt_lvl", a_level, e[13:8]);
        chk("a_lt_num", a_num_char, e[7:0]);
        chk("a_lt_ci", a_char_index, 0);
      end
    end
    if (b_load_timer === 1'b1) begin
      if (qb.size() == 0) chk("b_lt_unexp", b_load_timer, 0);
      else begin
        e = qb.pop_front();
        chk("b_lt_lvl", b_level, e[13:8]);
        chk("b_lt_num", b_num_char, e[7:0]);
        chk("b_lt_ci", b_char_index, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_game(input bit b, input logic [1:0] d);
    if (b) begin b_start = 1; b_sel = d; end
    else   begin a_start = 1; a_sel = d; end
    tick();
    a_start = 0;
    b_start = 0;
  endtask

  task automatic key(input bit b, input bit m);
    if (b) begin b_key_valid = 1; b_key_match = m; end
    else   begin a_key_valid = 1; a_key_match = m; end
    tick();
    a_key_valid = 0;
    b_key_valid = 0;
  endtask

  task automatic keys(input bit b, input int n);
    for (int i = 0; i < n; i++) key(b, 1'b1);
  endtask

  initial begin
    resetn = 0;
    a_start = 0; a_sel = 0; a_key_valid = 0;
    a_key_match = 0; a_timeout = 0;
    b_start = 0; b_sel = 0; b_key_valid = 0;
    b_key_match = 0; b_timeout = 0;
    repeat (3) tick();
    resetn = 1;
    tick();

    chk("rst_diff", a_difficulty, 1);
    chk("rst_lvl", a_level, 1);
    chk("rst_num", a_num_char, 4);
    chk("rst_ci", a_char_index, 0);
    chk("rst_score", a_score, 0);
    chk("rst_err", a_errors, 0);
    chk("rst_flags", {a_load_timer, a_timer_enable, a_round_active,
                      a_game_over, a_game_won}, 0);

    qa.push_back({6'd1, 8'd4});
    begin_game(0, 2'd0);
    chk("a_load1", a_load_timer, 1);
    chk("a_diff0", a_difficulty, 1);
    chk("a_ld_en", a_timer_enable, 0);
    tick();
    chk("a_play_act", a_round_active, 1);
    chk("a_play_en", a_timer_enable, 1);
    chk("a_play_lt", a_load_timer, 0);

    key(0, 1); chk("a_ci1", a_char_index, 1);
    key(0, 0); chk("a_ci_miss", a_char_index, 1);
    chk("a_err1", a_errors, 1);
    key(0, 1); chk("a_ci2", a_char_index, 2);
    key(0, 1); chk("a_ci3", a_char_index, 3);
    qa.push_back({6'd2, 8'd5});
    key(0, 1);
    chk("a_clr_act", a_round_active, 0);
    chk("a_clr_en", a_timer_enable, 0);
    chk("a_score4", a_score, 4);
    tick();
    chk("a_load2", a_load_timer, 1);
    tick();
    chk("a_play2", a_round_active, 1);

    keys(0, 2);
    chk("a_l2_ci2", a_char_index, 2);
    a_timeout = 1;
    tick();
    chk("a_over", a_game_over, 1);
    chk("a_over_en", a_timer_enable, 0);
    chk("a_over_act", a_round_active, 0);
    key(0, 1);
    key(0, 0);
    chk("a_over_score", a_score, 6);
    chk("a_over_err", a_errors, 1);
    chk("a_over_ci", a_char_index, 2);
    a_timeout = 0;

    qa.push_back({6'd1, 8'd4});
    begin_game(0, 2'd2);
    chk("a_rs_lvl", a_level, 1);
    chk("a_rs_score", a_score, 0);
    chk("a_rs_err", a_errors, 0);
    chk("a_rs_diff", a_difficulty, 2);
    chk("a_rs_over", a_game_over, 0);
    tick();

    keys(0, 3);
    a_timeout = 1;
    qa.push_back({6'd2, 8'd5});
    key(0, 1);
    chk("a_co_over", a_game_over, 0);
    chk("a_co_lvl", a_level, 1);
    tick();
    chk("a_co_lvl2", a_level, 2);
    chk("a_co_ldover", a_game_over, 0);
    tick();
    a_timeout = 0;
    chk("a_co_play", a_round_active, 1);
    chk("a_co_nover", a_game_over, 0);
    tick();
    chk("a_co_play2", a_round_active, 1);

    qb.push_back({6'd1, 8'd4});
    begin_game(1, 2'd3);
    chk("b_diff3", b_difficulty, 3);
    tick();
    qb.push_back({6'd2, 8'd5});
    keys(1, 4);
    tick(); tick();
    qb.push_back({6'd3, 8'd5});
    keys(1, 5);
    tick(); tick();
    keys(1, 4);
    chk("b_l3_act", b_round_active, 1);
    key(1, 1);
    chk("b_l3_num", b_num_char, 5);
    chk("b_l3_lvl", b_level, 3);
    tick();
    chk("b_won", b_game_won, 1);
    chk("b_won_en", b_timer_enable, 0);
    chk("b_won_over", b_game_over, 0);
    chk("b_won_score", b_score, 14);
    key(1, 1);
    chk("b_won_hold", b_score, 14);
    chk("b_q_empty", qb.size(), 0);

    qb.push_back({6'd1, 8'd4});
    begin_game(1, 2'd1);
    chk("b_rs_lvl", b_level, 1);
    chk("b_rs_won", b_game_won, 0);
    tick();
    key(1, 1);
    chk("b_rs_ci", b_char_index, 1);
    resetn = 0;
    tick();
    resetn = 1;
    chk("b_mr_act", b_round_active, 0);
    chk("b_mr_en", b_timer_enable, 0);
    chk("b_mr_ci", b_char_index, 0);
    chk("b_mr_score", b_score, 0);
    chk("b_mr_num", b_num_char, 4);
    chk("b_mr_lvl", b_level, 1);
    tick();
    chk("b_mr_lt", b_load_timer, 0);
    chk("b_mr_idle", b_round_active, 0);

    tick();
    chk("a_q_empty", qa.size(), 0);
    chk("b_q_end", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
